smi_frame_ctrl: RTL and testbench

Packet controller that sits behind the SMI bus port and turns the Pi's raw byte stream into LED framebuffer writes. It parses a small command protocol, sequences address and length, writes into a double-buffered framebuffer RAM, and schedules buffer swaps. It also drives the byte the Pi reads back on each SMI read cycle, which is used as a status register.

---
 rtl/smi_frame_pkg.sv | 36 +++
 rtl/smi_frame_timeout.sv | 24 ++
 rtl/smi_frame_ctrl.sv | 134 +++++++++++++
 tb/tb_smi_frame_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/smi_frame_pkg.sv
// Shared opcodes, FSM state type and status-byte layout for the SMI frame controller.
package smi_frame_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_SWAP   = 8'h02;
  localparam logic [7:0] CMD_CLRERR = 8'h03;

  localparam logic [3:0] PROTO_VERSION = 4'h1;

  localparam int unsigned STAT_ERR_BIT  = 7;
  localparam int unsigned STAT_BANK_BIT = 6;
  localparam int unsigned STAT_BUSY_BIT = 5;
  // Fixed-one marker: an idle, error-free controller on bank 0 reads back 8'h11.
  localparam int unsigned STAT_MARK_BIT = 4;

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StLenHi,
    StLenLo,
    StData
  } state_e;

  function automatic logic [7:0] status_byte(input logic err, input logic bank,
                                             input logic busy);
    logic [7:0] s;
    s                = {4'h0, PROTO_VERSION};
    s[STAT_ERR_BIT]  = err;
    s[STAT_BANK_BIT] = bank;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_MARK_BIT] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/smi_frame_timeout.sv
// Loadable 16-bit idle counter; expired is high while running with the count at LIMIT.
module smi_frame_timeout #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic run,
  output logic expired
);

  logic [15:0] count;

  assign expired = run && (count == 16'(LIMIT));

  always_ff @(posedge clk) begin
    if (reset || load) begin
      count <= 16'h0;
    end else if (run && !expired) begin
      count <= count + 16'h1;
    end
  end

endmodule

// File: rtl/smi_frame_ctrl.sv
// SMI packet parser driving double-buffered framebuffer writes and a status byte.
// Optional mid-packet timeout is built when SMI_FRAME_CTRL_TIMEOUT_EN is defined.
module smi_frame_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [ADDR_WIDTH:0]   fb_waddr,
  output logic [DATA_WIDTH-1:0] fb_wdata,
  output logic                  fb_we,
  output logic                  front_bank,
  output logic                  frame_swap
);
  import smi_frame_pkg::*;

  state_e                state;
  logic [7:0]            addr_hi;
  logic [7:0]            len_hi;
  logic [15:0]           len;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  err;
  logic                  timeout_hit;
  logic                  err_set;
  logic                  err_clr;
  logic [7:0]            rx_byte;

  assign rx_byte = rx_data[7:0];

`ifdef SMI_FRAME_CTRL_TIMEOUT_EN
  smi_frame_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .load   (rx_valid || (state == StIdle)),
    .run    (state != StIdle),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    err_set = 1'b0;
    err_clr = rd_req;
    if (rx_valid && (state == StIdle)) begin
      if (rx_byte == CMD_CLRERR) begin
        err_clr = 1'b1;
      end else if ((rx_byte != CMD_WRITE) && (rx_byte != CMD_SWAP)) begin
        err_set = 1'b1;
      end
    end
    // An arriving byte restarts the idle counter, so it takes priority over expiry.
    if (timeout_hit && !rx_valid) begin
      err_set = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      addr_hi    <= 8'h0;
      len_hi     <= 8'h0;
      len        <= 16'h0;
      offset     <= '0;
      err        <= 1'b0;
      fb_we      <= 1'b0;
      fb_waddr   <= '0;
      fb_wdata   <= '0;
      front_bank <= 1'b0;
      frame_swap <= 1'b0;
      tx_data    <= '0;
    end else begin
      fb_we      <= 1'b0;
      frame_swap <= 1'b0;
      tx_data    <= DATA_WIDTH'(status_byte(err, front_bank, state != StIdle));

      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end

      if (rx_valid) begin
        unique case (state)
          StIdle: begin
            if (rx_byte == CMD_WRITE) begin
              state <= StAddrHi;
            end else if (rx_byte == CMD_SWAP) begin
              front_bank <= ~front_bank;
              frame_swap <= 1'b1;
            end
          end
          StAddrHi: begin
            addr_hi <= rx_byte;
            state   <= StAddrLo;
          end
          StAddrLo: begin
            offset <= ADDR_WIDTH'({addr_hi, rx_byte});
            state  <= StLenHi;
          end
          StLenHi: begin
            len_hi <= rx_byte;
            state  <= StLenLo;
          end
          StLenLo: begin
            len   <= {len_hi, rx_byte};
            state <= ({len_hi, rx_byte} != 16'h0) ? StData : StIdle;
          end
          StData: begin
            fb_we    <= 1'b1;
            fb_waddr <= {~front_bank, offset};
            fb_wdata <= rx_data;
            offset   <= offset + 1'b1;
            len      <= len - 16'h1;
            if (len == 16'h1) begin
              state <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end else if (timeout_hit) begin
        state <= StIdle;
      end
    end
  end

endmodule

// File: tb/tb_smi_frame_ctrl.sv
// Directed, table-driven bench for smi_frame_ctrl.
module tb_smi_frame_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_valid = 1'b0;
  logic        rd_req = 1'b0;
  logic [7:0]  tx_data;
  logic [12:0] fb_waddr;
  logic [7:0]  fb_wdata;
  logic        fb_we;
  logic        front_bank;
  logic        frame_swap;

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  int n;

  typedef struct {
    logic [7:0] rx;
    logic       vld;
    logic       rd;
    logic       swap;
    logic       bank;
    logic [7:0] tx;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] dat[3];

  smi_frame_ctrl #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (12),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rd_req    (rd_req),
    .tx_data   (tx_data),
    .fb_waddr  (fb_waddr),
    .fb_wdata  (fb_wdata),
    .fb_we     (fb_we),
    .front_bank(front_bank),
    .frame_swap(frame_swap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fb_we === 1'b1) wr_count++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // SWAP / bad-opcode / read-to-clear sequence, starting from bank 0 and err 0
    vecs[0] = '{8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 8'h51};
    vecs[1] = '{8'h7E, 1'b1, 1'b0, 1'b0, 1'b1, 8'hD1};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h51};
    vecs[3] = '{8'h7E, 1'b1, 1'b1, 1'b0, 1'b1, 8'hD1};
    vecs[4] = '{8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 8'h51};
    vecs[5] = '{8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 8'h11};
    vecs[6] = '{8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 8'h91};
    vecs[7] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h91};
    vecs[8] = '{8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 8'hD1};
    vecs[9] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h51};
    dat[0] = 8'hAA;
    dat[1] = 8'hBB;
    dat[2] = 8'hCC;

    repeat (3) tick();
    chk("rst_tx", tx_data, 8'h00);
    chk("rst_we", fb_we, 1'b0);
    chk("rst_waddr", fb_waddr, 13'h0);
    chk("rst_wdata", fb_wdata, 8'h0);
    chk("rst_bank", front_bank, 1'b0);
    chk("rst_swap", frame_swap, 1'b0);
    reset = 1'b0;
    tick();
    chk("tx_after_rst", tx_data, 8'h11);

    // WRITE 0x0010 len 3, back-to-back bytes
    send(8'h01); send(8'h00); send(8'h10); send(8'h00); send(8'h03);
    chk("busy_hdr", tx_data, 8'h31);
    for (int i = 0; i < 3; i++) begin
      send(dat[i]);
      chk("wr_we", fb_we, 1'b1);
      chk("wr_addr", fb_waddr, 13'h1010 + i);
      chk("wr_data", fb_wdata, dat[i]);
    end
    tick();
    chk("we_one_cycle", fb_we, 1'b0);
    tick();
    chk("idle_after_wr", tx_data, 8'h11);
    chk("wr_count3", wr_count, 3);

    // Offset wrap at 0xFFF
    send(8'h01); send(8'h0F); send(8'hFF); send(8'h00); send(8'h02);
    send(8'hE1);
    chk("wrap_addr0", fb_waddr, 13'h1FFF);
    send(8'hE2);
    chk("wrap_addr1", fb_waddr, 13'h1000);
    chk("wrap_data1", fb_wdata, 8'hE2);
    tick(); tick();

    for (int i = 0; i < 10; i++) begin
      rx_data  = vecs[i].rx;
      rx_valid = vecs[i].vld;
      rd_req   = vecs[i].rd;
      tick();
      rx_valid = 1'b0;
      rd_req   = 1'b0;
      rx_data  = 8'h0;
      chk($sformatf("vec%0d_swap", i), frame_swap, vecs[i].swap);
      chk($sformatf("vec%0d_bank", i), front_bank, vecs[i].bank);
      tick();
      chk($sformatf("vec%0d_tx", i), tx_data, vecs[i].tx);
    end

    // Front bank is 1, so writes land in bank 0
    send(8'h01); send(8'h00); send(8'h20); send(8'h00); send(8'h01);
    send(8'h5A);
    chk("bank0_addr", fb_waddr, 13'h0020);
    chk("bank0_data", fb_wdata, 8'h5A);
    tick(); tick();

    // len 0: header only
    n = wr_count;
    send(8'h01); send(8'h00); send(8'h30); send(8'h00); send(8'h00);
    tick();
    chk("len0_idle", tx_data, 8'h51);
    tick();
    chk("len0_nowr", wr_count, n);

    // Stall mid-packet
    n = wr_count;
    send(8'h01); send(8'h00); send(8'h40); send(8'h00); send(8'h05);
    repeat (50) tick();
    chk("stall_busy", tx_data, 8'h71);
    repeat (60) tick();
`ifdef SMI_FRAME_CTRL_TIMEOUT_EN
    chk("timeout_err", tx_data, 8'hD1);
`else
    chk("no_timeout", tx_data, 8'h71);
`endif
    chk("stall_nowr", wr_count, n);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset in DATA after 1 of 4 bytes
    send(8'h01); send(8'h00); send(8'h05); send(8'h00); send(8'h04);
    send(8'h11);
    chk("pre_rst_we", fb_we, 1'b1);
    chk("pre_rst_addr", fb_waddr, 13'h1005);
    chk("pre_rst_data", fb_wdata, 8'h11);
    reset = 1'b1;
    tick();
    chk("mid_rst_we", fb_we, 1'b0);
    chk("mid_rst_addr", fb_waddr, 13'h0);
    chk("mid_rst_data", fb_wdata, 8'h0);
    chk("mid_rst_bank", front_bank, 1'b0);
    chk("mid_rst_swap", frame_swap, 1'b0);
    chk("mid_rst_tx", tx_data, 8'h00);
    n = wr_count;
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_tx", tx_data, 8'h11);
    send(8'h99); send(8'h99); send(8'h99);
    tick(); tick();
    chk("post_rst_err", tx_data, 8'h91);
    chk("post_rst_nowr", wr_count, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
